// File: rtl/bus_ctrl.sv
// bus_ctrl: SRAM-style external bus cycle controller with programmable wait states.
// Optional BUS_CTRL_CODE_WP_EN blocks external writes to the code segment.
module bus_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        load,
  input  logic        store,
  input  logic        code_seg,
  input  logic        data_seg,
  input  logic        stack_seg,
  input  logic [23:0] addr_out,
  input  logic [15:0] data_out,
  output logic        ready,
  output logic [15:0] data_in,
  output logic [23:0] mem_addr,
  output logic [1:0]  mem_seg,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_wait,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  localparam logic [CNT_W-1:0] WAIT_V = CNT_W'(WAIT_CYCLES);
  state_t state;
  logic armed, rd, wr_blk, req, wp;
  logic [1:0] seg;
  logic [CNT_W-1:0] cnt;
  assign req = armed & (load | store);
  // data_seg is the default encoding, so it only matters when nothing else is selected
  assign seg = code_seg ? 2'b01 : stack_seg ? 2'b10 : 2'b00;
`ifdef BUS_CTRL_CODE_WP_EN
  assign wp = store & ~load & (seg == 2'b01);
`else
  assign wp = 1'b0;
`endif
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      armed     <= 1'b1;
      rd        <= 1'b0;
      wr_blk    <= 1'b0;
      cnt       <= '0;
      ready     <= 1'b0;
      data_in   <= '0;
      mem_addr  <= '0;
      mem_seg   <= 2'b00;
      mem_wdata <= '0;
      mem_ce_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      bus_err   <= 1'b0;
    end else begin
      if (!load && !store) armed <= 1'b1;
      case (state)
        IDLE: if (req) begin
          state     <= SETUP;
          mem_addr  <= addr_out;
          mem_wdata <= data_out;
          mem_seg   <= seg;
          rd        <= load;
          wr_blk    <= wp;
          armed     <= 1'b0;
          mem_ce_n  <= 1'b0;
          if ((load & store) | wp) bus_err <= 1'b1;
        end
        SETUP: begin
          state    <= ACCESS;
          cnt      <= '0;
          mem_oe_n <= ~rd;
          mem_we_n <= rd | wr_blk;
        end
        ACCESS: if (cnt == WAIT_V && !mem_wait) begin
          state    <= DONE;
          ready    <= 1'b1;
          mem_ce_n <= 1'b1;
          mem_oe_n <= 1'b1;
          mem_we_n <= 1'b1;
          if (rd) data_in <= mem_rdata;
        end else if (cnt != WAIT_V) cnt <= cnt + 1'b1;
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: directed checks of bus_ctrl latency, strobes, re-arm, collision and reset.
module tb_bus_ctrl;
  logic sys_clk = 0, sys_rst_n = 1;
  logic load = 0, store = 0, code_seg = 0, data_seg = 0, stack_seg = 0;
  logic [23:0] addr_out = '0;
  logic [15:0] data_out = '0, mem_rdata = '0;
  logic mem_wait = 0;
  logic ready, mem_ce_n, mem_oe_n, mem_we_n, bus_err;
  logic [15:0] data_in, mem_wdata;
  logic [23:0] mem_addr;
  logic [1:0] mem_seg;
  int n_cmp = 0, n_err = 0;
  int fr, nrdy, noe, nwe, nce;
`ifdef BUS_CTRL_CODE_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  bus_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .load(load), .store(store),
    .code_seg(code_seg), .data_seg(data_seg), .stack_seg(stack_seg),
    .addr_out(addr_out), .data_out(data_out), .ready(ready), .data_in(data_in),
    .mem_addr(mem_addr), .mem_seg(mem_seg), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_wait(mem_wait), .mem_ce_n(mem_ce_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .bus_err(bus_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge 0 samples the request; i counts edges after it. mem_wait is high for edges ws+1..ws+wn.
  task automatic run(input int n, input int ws, input int wn,
                     output int f, output int r, output int o, output int w, output int c);
    f = -1; r = 0; o = 0; w = 0; c = 0;
    for (int i = 0; i <= n; i++) begin
      tick();
      if (ready) begin r++; if (f < 0) f = i; end
      o += int'(!mem_oe_n);
      w += int'(!mem_we_n);
      c += int'(!mem_ce_n);
      mem_wait = (i >= ws) && (i < ws + wn);
    end
    mem_wait = 0;
  endtask

  task automatic drop();
    load = 0; store = 0; code_seg = 0; data_seg = 0; stack_seg = 0;
    tick();
  endtask

  initial begin
    #1 sys_rst_n = 0;
    repeat (2) tick();
    chk("rst_ready", ready, 0);
    chk("rst_ce", mem_ce_n, 1);
    chk("rst_oe_we", {mem_oe_n, mem_we_n}, 2'b11);
    chk("rst_data_in", data_in, 0);
    chk("rst_addr_seg", {mem_addr, mem_seg}, 0);
    chk("rst_err", bus_err, 0);
    sys_rst_n = 1;
    tick();

    // code read, load held well past ready: exactly one bus cycle
    load = 1; code_seg = 1; addr_out = 24'h000100; mem_rdata = 16'hF878;
    run(12, 99, 0, fr, nrdy, noe, nwe, nce);
    chk("rd_seg", mem_seg, 2'b01);
    chk("rd_addr", mem_addr, 24'h000100);
    chk("rd_ready_at", fr, 4);
    chk("rd_ready_cnt", nrdy, 1);
    chk("rd_oe_cnt", noe, 3);
    chk("rd_ce_cnt", nce, 4);
    chk("rd_we_cnt", nwe, 0);
    chk("rd_data", data_in, 16'hF878);
    chk("rd_err", bus_err, 0);

    // one low cycle re-arms
    drop();
    load = 1; code_seg = 1; addr_out = 24'h000102; mem_rdata = 16'hA55A;
    tick();
    addr_out = 24'h777777; code_seg = 0; stack_seg = 1;
    run(8, 99, 0, fr, nrdy, noe, nwe, nce);
    chk("rd2_ready_at", fr, 3);
    chk("rd2_addr_frozen", mem_addr, 24'h000102);
    chk("rd2_seg_frozen", mem_seg, 2'b01);
    chk("rd2_data", data_in, 16'hA55A);
    drop();

    // data write stretched by mem_wait for three cycles at the final count
    store = 1; data_seg = 1; addr_out = 24'h004000; data_out = 16'h0F0F; mem_rdata = 16'hDEAD;
    run(10, 3, 3, fr, nrdy, noe, nwe, nce);
    chk("wr_ready_at", fr, 7);
    chk("wr_we_cnt", nwe, 6);
    chk("wr_oe_cnt", noe, 0);
    chk("wr_wdata", mem_wdata, 16'h0F0F);
    chk("wr_seg", mem_seg, 2'b00);
    chk("wr_data_in_kept", data_in, 16'hA55A);
    drop();

    // code-segment store: blocked only when write protection is built in
    store = 1; code_seg = 1; addr_out = 24'h000200; data_out = 16'h1111;
    run(8, 99, 0, fr, nrdy, noe, nwe, nce);
    chk("cs_ready_at", fr, 4);
    chk("cs_we_cnt", nwe, WP ? 0 : 3);
    chk("cs_err", bus_err, WP ? 1 : 0);
    drop();
    if (WP) begin
      sys_rst_n = 0; #1 sys_rst_n = 1;
      tick();
    end

    // collision: load and store together run a read and set the sticky error
    load = 1; store = 1; stack_seg = 1; addr_out = 24'h00ABCD; mem_rdata = 16'h1234;
    run(8, 99, 0, fr, nrdy, noe, nwe, nce);
    chk("col_ready_at", fr, 4);
    chk("col_oe_cnt", noe, 3);
    chk("col_we_cnt", nwe, 0);
    chk("col_data", data_in, 16'h1234);
    chk("col_seg", mem_seg, 2'b10);
    chk("col_err", bus_err, 1);
    drop();
    store = 1; data_seg = 1; data_out = 16'h2222;
    run(8, 99, 0, fr, nrdy, noe, nwe, nce);
    chk("clean_we_cnt", nwe, 3);
    chk("clean_err_sticky", bus_err, 1);
    drop();

    // reset in the middle of ACCESS aborts at once
    load = 1; code_seg = 1; addr_out = 24'h000300; mem_rdata = 16'h0BAD;
    repeat (3) tick();
    chk("mid_oe_low", mem_oe_n, 0);
    sys_rst_n = 0;
    #1;
    chk("mid_rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_err", bus_err, 0);
    tick();
    sys_rst_n = 1;
    // armed after reset: the still-held load is accepted
    run(8, 99, 0, fr, nrdy, noe, nwe, nce);
    chk("post_rst_ready_at", fr, 4);
    chk("post_rst_data", data_in, 16'h0BAD);
    chk("post_rst_err", bus_err, 0);
    drop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
